// File: rtl/vga_mode_loader.sv
// Programs the VGA timing Config block with one of the built-in video modes:
// streams eight register writes, then waits (bounded) for Config's load pulse.
module vga_mode_loader #(
   parameter int unsigned ADDR_WIDTH   = 3,
   parameter int unsigned DATA_WIDTH   = 12,
   parameter int unsigned MODE_WIDTH   = 2,
   parameter int unsigned LOAD_TIMEOUT = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [MODE_WIDTH-1:0] mode_sel_i,
   input  logic                  load_config_i,
   output logic                  valid_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [MODE_WIDTH-1:0] mode_cur_o
);

   localparam int unsigned CNT_WIDTH = $clog2(LOAD_TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(7);
   localparam logic [CNT_WIDTH-1:0]  TIMEOUT_CNT = CNT_WIDTH'(LOAD_TIMEOUT - 1);

   // Mode table; unlisted modes (including 3) reuse the 640x480 set.
   function automatic logic [DATA_WIDTH-1:0] mode_value(input logic [MODE_WIDTH-1:0] mode,
                                                        input logic [ADDR_WIDTH-1:0] addr);
      logic [10:0] v;
      v = 11'd0;
      case (32'(mode))
         1: case (32'(addr))
               0: v = 11'd40;   1: v = 11'd88;
               2: v = 11'd1;    3: v = 11'd23;
               4: v = 11'd1055; 5: v = 11'd800;
               6: v = 11'd627;  7: v = 11'd600;
               default: v = 11'd0;
            endcase
         2: case (32'(addr))
               0: v = 11'd24;   1: v = 11'd160;
               2: v = 11'd3;    3: v = 11'd29;
               4: v = 11'd1343; 5: v = 11'd1024;
               6: v = 11'd805;  7: v = 11'd768;
               default: v = 11'd0;
            endcase
         default: case (32'(addr))
               0: v = 11'd16;   1: v = 11'd48;
               2: v = 11'd10;   3: v = 11'd33;
               4: v = 11'd799;  5: v = 11'd640;
               6: v = 11'd524;  7: v = 11'd480;
               default: v = 11'd0;
            endcase
      endcase
      return DATA_WIDTH'(v);
   endfunction

   logic [1:0]            state_q, state_d;
   logic [MODE_WIDTH-1:0] mode_q, mode_d;
   logic [MODE_WIDTH-1:0] mode_cur_q, mode_cur_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         mode_q     <= '0;
         mode_cur_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         mode_cur_q <= mode_cur_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   // Next-state logic; outputs are computed one cycle ahead so they leave registered.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      mode_cur_d = mode_cur_q;
      addr_d     = addr_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = error_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_WRITE;
               mode_d  = mode_sel_i;
               error_d = 1'b0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               addr_d  = '0;
               data_d  = mode_value(mode_sel_i, '0);
            end
         end
         ST_WRITE: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_WAIT;
               valid_d = 1'b0;
               cnt_d   = '0;
            end else begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               data_d = mode_value(mode_q, addr_q + ADDR_WIDTH'(1));
            end
         end
         ST_WAIT: begin
            // A load pulse on the final timeout cycle still wins.
            if (load_config_i) begin
               state_d    = ST_IDLE;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               mode_cur_d = mode_q;
            end else if (cnt_q == TIMEOUT_CNT) begin
               state_d = ST_IDLE;
               error_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign valid_o    = valid_q;
   assign addr_o     = addr_q;
   assign data_o     = data_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign mode_cur_o = mode_cur_q;

endmodule

// File: tb/tb_vga_mode_loader.sv
// Scoreboard bench for vga_mode_loader: the driver queues expected writes and
// outcomes from a table model; an independent monitor checks every DUT output event.
module tb_vga_mode_loader;

   localparam int unsigned TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode_sel;
   logic        load_config;
   logic        valid;
   logic [2:0]  addr;
   logic [11:0] data;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  mode_cur;

   vga_mode_loader dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .mode_sel_i    (mode_sel),
      .load_config_i (load_config),
      .valid_o       (valid),
      .addr_o        (addr),
      .data_o        (data),
      .busy_o        (busy),
      .done_o        (done),
      .error_o       (error),
      .mode_cur_o    (mode_cur)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;   // 0 write, 1 done, 2 error
      int addr;
      int data;
      int mode;
   } exp_t;

   exp_t exp_q[$];
   int   table_v[4][8] = '{'{16, 48, 10, 33, 799, 640, 524, 480},
                           '{40, 88, 1, 23, 1055, 800, 627, 600},
                           '{24, 160, 3, 29, 1343, 1024, 805, 768},
                           '{16, 48, 10, 33, 799, 640, 524, 480}};
   int   checks   = 0;
   int   failures = 0;
   int   model_mode_cur = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every output event must match the head of the expectation queue.
   initial begin
      bit   err_prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (valid === 1'b1) begin
               if (exp_q.size() == 0) check("unexpected_write", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("write_kind", 0, e.kind);
                  check("write_addr", int'(addr), e.addr);
                  check("write_data", int'(data), e.data);
                  check("write_err_clear", int'(error), 0);
                  check("write_busy", int'(busy), 1);
               end
            end
            if (done === 1'b1) begin
               if (exp_q.size() == 0) check("unexpected_done", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("done_kind", 1, e.kind);
                  check("done_mode_cur", int'(mode_cur), e.mode);
                  check("done_err", int'(error), 0);
                  check("done_busy", int'(busy), 0);
               end
            end
            if (error === 1'b1 && !err_prev) begin
               if (exp_q.size() == 0) check("unexpected_error", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("error_kind", 2, e.kind);
                  check("error_mode_cur", int'(mode_cur), e.mode);
                  check("error_done", int'(done), 0);
                  check("error_busy", int'(busy), 0);
               end
            end
         end
         err_prev = (error === 1'b1);
      end
   end

   function automatic void push(input int kind, input int a, input int d, input int m);
      exp_t e;
      e.kind = kind; e.addr = a; e.data = d; e.mode = m;
      exp_q.push_back(e);
   endfunction

   // One load sequence; delay >= TIMEOUT means Load_config is never pulsed.
   task automatic run_load(input int mode, input int delay, input bit noise);
      for (int a = 0; a < 8; a++) push(0, a, table_v[mode][a], 0);
      if (delay < int'(TIMEOUT)) begin
         model_mode_cur = mode;
         push(1, 0, 0, mode);
      end else begin
         push(2, 0, 0, model_mode_cur);
      end
      start    = 1'b1;
      mode_sel = 2'(mode);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (noise) begin
            start       = 1'($urandom_range(0, 1));
            load_config = 1'($urandom_range(0, 1));
            mode_sel    = 2'($urandom_range(0, 3));
         end
         @(posedge clk); #1;
      end
      start       = 1'b0;
      load_config = 1'b0;
      for (int k = 0; k < int'(TIMEOUT); k++) begin
         load_config = (k == delay);
         @(posedge clk); #1;
         load_config = 1'b0;
         if (k == delay) break;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got 0 expected 1 (simulation did not finish)");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; mode_sel = '0; load_config = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_valid", int'(valid), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_data", int'(data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_error", int'(error), 0);
      check("rst_mode_cur", int'(mode_cur), 0);
      mon_en = 1'b1;

      run_load(1, 3, 1'b0);
      run_load(2, 1000, 1'b0);
      run_load(0, 5, 1'b1);

      // Reset while mode 2 is mid-stream at address 3.
      for (int a = 0; a < 4; a++) push(0, a, table_v[2][a], 0);
      start = 1'b1; mode_sel = 2'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_mode_cur = 0;
      check("abort_valid", int'(valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_mode_cur", int'(mode_cur), 0);
      @(posedge clk); #1;
      check("abort_idle_valid", int'(valid), 0);

      run_load(0, 2, 1'b0);
      run_load(3, int'(TIMEOUT) - 1, 1'b0);
      run_load(1, int'(TIMEOUT), 1'b0);

      for (int n = 0; n < 20; n++) begin
         int m, d;
         m = $urandom_range(0, 3);
         d = ($urandom_range(0, 3) == 0) ? 999 : $urandom_range(0, int'(TIMEOUT) - 1);
         run_load(m, d, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
         #0;
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("final_mode_cur", int'(mode_cur), model_mode_cur);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
